// File: rtl/cc_out_capture.sv
// cc_out_capture
//   Captures 20-bit cc output vectors into a 4-deep FIFO. Each entry is
//   tagged with a 4-bit sequence number. The head entry is presented on
//   registered outputs.
//
// Ports
//   clock     : sole clock, rising edge
//   resetn    : synchronous reset, active low
//   in_valid  : capture in_po this cycle
//   in_po     : cc output vector po19..po00
//   flush     : discard all buffered entries
//   out_valid : out_data/out_seq/out_par hold the head entry
//   out_ready : consumer takes the head entry this cycle
//   out_data  : oldest buffered vector
//   out_seq   : capture tag of out_data
//   level     : number of buffered entries, 0..4
//   drop_cnt  : captures lost to a full buffer, saturates at 255
//   out_par   : XOR of out_data (0 when parity is disabled)
//
// Build option
//   CC_CAPTURE_PARITY_EN : store a parity bit per entry and drive out_par.
//                          When undefined, out_par is tied to 0.

module cc_out_capture (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [19:0] in_po,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_data,
    output logic [3:0]  out_seq,
    output logic [2:0]  level,
    output logic [7:0]  drop_cnt,
    output logic        out_par
);

    localparam int DEPTH = 4;

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [19:0] data_q [DEPTH];
    logic [19:0] data_d [DEPTH];
    logic [3:0]  tagm_q [DEPTH];
    logic [3:0]  tagm_d [DEPTH];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  level_q, level_d;
    logic [3:0]  tag_q, tag_d;
    logic [7:0]  drop_q, drop_d;
    logic        out_valid_q, out_valid_d;
    logic [19:0] out_data_q, out_data_d;
    logic [3:0]  out_seq_q, out_seq_d;

    logic flushing, pop, push, drop;

`ifdef CC_CAPTURE_PARITY_EN
    logic par_q [DEPTH];
    logic par_d [DEPTH];
    logic out_par_q, out_par_d;
`endif

    always_comb begin
        state_d  = flush ? ST_FLUSH : ST_RUN;
        data_d   = data_q;
        tagm_d   = tagm_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        tag_d    = tag_q;
        drop_d   = drop_q;
`ifdef CC_CAPTURE_PARITY_EN
        par_d    = par_q;
`endif

        // The cycle that raises flush and every cycle spent in FLUSH ignore
        // both sides of the FIFO; flush wins over a simultaneous push/pop.
        flushing = flush || (state_q == ST_FLUSH);
        pop      = out_valid_q && out_ready && !flushing;
        push     = in_valid && !flushing && ((level_q != 3'(DEPTH)) || pop);
        drop     = in_valid && !flushing && (level_q == 3'(DEPTH)) && !pop;

        if (flushing) begin
            level_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = in_po;
                tagm_d[wr_ptr_q] = tag_q;
`ifdef CC_CAPTURE_PARITY_EN
                par_d[wr_ptr_q]  = ^in_po;
`endif
                wr_ptr_d = wr_ptr_q + 2'd1;
                tag_d    = tag_q + 4'd1;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 2'd1;
            level_d = level_q + {2'b00, push} - {2'b00, pop};
        end

        if (drop && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;

        // Head is taken from the next-state storage so a push into an empty
        // buffer shows up on the outputs right after the capturing edge.
        // While the head is not popped its slot is never written, so the
        // registered outputs stay stable under back-pressure.
        out_valid_d = (level_d != 3'd0);
        out_data_d  = data_d[rd_ptr_d];
        out_seq_d   = tagm_d[rd_ptr_d];
`ifdef CC_CAPTURE_PARITY_EN
        out_par_d   = par_d[rd_ptr_d];
`endif
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= ST_RUN;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            tag_q       <= '0;
            drop_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_seq_q   <= '0;
`ifdef CC_CAPTURE_PARITY_EN
            out_par_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            tag_q       <= tag_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_seq_q   <= out_seq_d;
`ifdef CC_CAPTURE_PARITY_EN
            out_par_q   <= out_par_d;
`endif
        end
        // Entry storage needs no reset: it is only visible through a valid head.
        data_q <= data_d;
        tagm_q <= tagm_d;
`ifdef CC_CAPTURE_PARITY_EN
        par_q  <= par_d;
`endif
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_seq   = out_seq_q;
    assign level     = level_q;
    assign drop_cnt  = drop_q;
`ifdef CC_CAPTURE_PARITY_EN
    assign out_par   = out_par_q;
`else
    assign out_par   = 1'b0;
`endif

endmodule

// File: tb/tb_cc_out_capture.sv
// Testbench for cc_out_capture: directed stimulus pushes expected entries
// into a scoreboard queue; an independent monitor compares the head entry
// on every cycle out_valid is high and pops the queue on a handshake.

module tb_cc_out_capture;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [19:0] in_po;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic [3:0]  out_seq;
    logic [2:0]  level;
    logic [7:0]  drop_cnt;
    logic        out_par;

    cc_out_capture dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_po     (in_po),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_seq   (out_seq),
        .level     (level),
        .drop_cnt  (drop_cnt),
        .out_par   (out_par)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [19:0] d;
        logic [3:0]  t;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  exp_tag;
    int          n_chk  = 0;
    int          n_fail = 0;

`ifdef CC_CAPTURE_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    function automatic logic exp_par(input logic [19:0] d);
        return PAR_ON & (^d);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares head entry against scoreboard front.
    always @(negedge clock) begin
        if (resetn === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb[0].d));
                chk("out_seq",  32'(out_seq),  32'(sb[0].t));
                chk("out_par",  32'(out_par),  32'(exp_par(sb[0].d)));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic iv, input logic [19:0] po, input logic rdy,
                        input logic fl, input logic acc);
        in_valid  = iv;
        in_po     = po;
        out_ready = rdy;
        flush     = fl;
        if (acc) begin
            sb.push_back('{d: po, t: exp_tag});
            exp_tag = exp_tag + 4'd1;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
        sb.delete();
        exp_tag = 4'd0;
        resetn  = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    endtask

    logic [7:0] drop_save;

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_po = '0; flush = 1'b0; out_ready = 1'b0;
        exp_tag = 4'd0;
        @(posedge clock); #1;
        do_reset();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_seq",   32'(out_seq),   32'd0);
        chk("rst_level",     32'(level),     32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        chk("rst_out_par",   32'(out_par),   32'd0);

        // Single capture, 1-cycle latency
        step(1'b1, 20'h00001, 1'b1, 1'b0, 1'b1);
        chk("single_level1", 32'(level), 32'd1);
        chk("single_valid1", 32'(out_valid), 32'd1);
        chk("single_seq0",   32'(out_seq), 32'd0);
        step(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
        chk("single_level0", 32'(level), 32'd0);
        chk("single_valid0", 32'(out_valid), 32'd0);

        // Overflow: 6 captures into a stalled buffer
        do_reset();
        for (int i = 1; i <= 6; i++)
            step(1'b1, 20'(i), 1'b0, 1'b0, (i <= 4) ? 1'b1 : 1'b0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_drop",  32'(drop_cnt), 32'd2);
        drain(4);
        chk("ovf_drained", 32'(level), 32'd0);

        // Full buffer with simultaneous push and pop
        for (int i = 0; i < 4; i++)
            step(1'b1, 20'h11 + 20'(i), 1'b0, 1'b0, 1'b1);
        chk("full_level", 32'(level), 32'd4);
        step(1'b1, 20'hABCDE, 1'b1, 1'b0, 1'b1);
        chk("pushpop_level", 32'(level), 32'd4);
        chk("pushpop_drop",  32'(drop_cnt), 32'd2);
        drain(4);
        chk("pushpop_drained", 32'(level), 32'd0);

        // Tag wrap with continuous drain
        do_reset();
        for (int i = 0; i < 17; i++)
            step(1'b1, 20'h100 + 20'(i), 1'b1, 1'b0, 1'b1);
        chk("wrap_level", 32'(level), 32'd1);
        chk("wrap_seq",   32'(out_seq), 32'd0);
        drain(1);
        chk("wrap_drained", 32'(level), 32'd0);

        // Flush mid-operation with a simultaneous capture
        for (int i = 0; i < 3; i++)
            step(1'b1, 20'h200 + 20'(i), 1'b0, 1'b0, 1'b1);
        chk("fl_level3", 32'(level), 32'd3);
        drop_save = drop_cnt;
        step(1'b1, 20'h55555, 1'b0, 1'b1, 1'b0);
        sb.delete();
        chk("fl_level0", 32'(level), 32'd0);
        chk("fl_valid0", 32'(out_valid), 32'd0);
        chk("fl_drop",   32'(drop_cnt), 32'(drop_save));
        step(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 20'h77777, 1'b1, 1'b0, 1'b1);
        chk("fl_resume_level", 32'(level), 32'd1);
        chk("fl_tag_cont",     32'(out_seq), 32'd4);
        drain(1);

        // Reset mid-operation
        step(1'b1, 20'h30001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 20'h30002, 1'b0, 1'b0, 1'b1);
        chk("mid_level2", 32'(level), 32'd2);
        resetn = 1'b0;
        step(1'b1, 20'h99999, 1'b1, 1'b0, 1'b0);
        sb.delete();
        exp_tag = 4'd0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_data),  32'd0);
        chk("mid_rst_seq",   32'(out_seq),   32'd0);
        chk("mid_rst_level", 32'(level),     32'd0);
        chk("mid_rst_drop",  32'(drop_cnt),  32'd0);
        chk("mid_rst_par",   32'(out_par),   32'd0);
        resetn = 1'b1;
        step(1'b1, 20'h00042, 1'b1, 1'b0, 1'b1);
        chk("post_rst_level", 32'(level), 32'd1);
        drain(1);

        // Parity
        step(1'b1, 20'h00007, 1'b1, 1'b0, 1'b1);
        chk("par_7", 32'(out_par), 32'(PAR_ON));
        step(1'b1, 20'h00003, 1'b1, 1'b0, 1'b1);
        chk("par_3", 32'(out_par), 32'd0);
        drain(1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("end_level", 32'(level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cc_out_capture.md
CC_OUT_CAPTURE -- requirements
Module: cc_out_capture

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn  input  1  synchronous reset, active-low, sampled on rising edge of clock.
REQ-003 SHALL have port in_valid  input  1  the 20-bit cc response on in_po is to be captured this cycle.
REQ-004 SHALL have port in_po  input  20  cc output vector po19..po00, bit n = po n.
REQ-005 SHALL have port flush  input  1  discard all buffered entries.
REQ-006 SHALL have port out_valid  output  1  out_data/out_seq hold a valid entry.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the entry this cycle.
REQ-008 SHALL have port out_data  output  20  oldest buffered vector.
REQ-009 SHALL have port out_seq  output  4  capture sequence tag of out_data.
REQ-010 SHALL have port level  output  3  number of buffered entries, 0..4.
REQ-011 SHALL have port drop_cnt  output  8  count of captures lost to a full buffer.
REQ-012 SHALL have port out_par  output  1  parity of out_data (see Configuration).

Function
REQ-013 SHALL buffer up to 4 entries FIFO-ordered; each entry holds in_po plus a 4-bit tag.
REQ-014 SHALL push when in_valid=1 and (level<4 or pop occurs the same cycle); pop = out_valid & out_ready.
REQ-015 SHALL apply push and pop in the same cycle at any level, leaving level unchanged.
REQ-016 SHALL, when in_valid=1, level=4 and no pop, discard in_po and increment drop_cnt, saturating at 255.
REQ-017 SHALL assign tags from a 4-bit counter incremented on every accepted push, wrapping 15->0; dropped captures do not consume a tag.
REQ-018 SHALL present the head entry registered: a push into an empty buffer makes out_valid=1 on the following cycle (1-cycle latency).
REQ-019 SHALL hold out_data, out_seq and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL drive out_valid=0 whenever level=0; out_data value is don't-care when out_valid=0.
REQ-021 SHALL implement a 2-state control machine: RUN (normal) and FLUSH.
REQ-022 SHALL enter FLUSH from RUN when flush=1; in FLUSH: level->0, out_valid=0, pushes ignored without counting as drops.
REQ-023 SHALL return from FLUSH to RUN on the first cycle flush=0; the tag counter and drop_cnt are not cleared by flush.
REQ-024 SHALL give flush priority over a simultaneous push and pop in the same cycle (both ignored).
REQ-025 SHALL update level combinationally-free: level is a register reflecting the post-edge count.

Reset
REQ-026 SHALL, when resetn=0 at a rising edge, set state=RUN, level=0, out_valid=0, out_data=0, out_seq=0, out_par=0, tag counter=0, drop_cnt=0.
REQ-027 SHALL let reset override every other input, including mid-burst and during FLUSH; buffered entries are lost.
REQ-028 SHALL accept a push on the first cycle after resetn returns to 1.

Configuration
REQ-029 SHALL, with macro CC_CAPTURE_PARITY_EN defined, store an even-parity bit per entry computed at push time and drive out_par = XOR of the stored vector for the head entry.
REQ-030 SHALL, without CC_CAPTURE_PARITY_EN, tie out_par to 0 and omit the parity storage.

Verification
REQ-031 SHALL cover single capture: reset, in_valid=1 with in_po=20'h00001 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=20'h00001, out_seq=0, level=1; cycle after, level=0, out_valid=0.
REQ-032 SHALL cover overflow: out_ready=0, 6 consecutive captures 20'h1..20'h6 -> level=4, drop_cnt=2, then draining yields 1,2,3,4 with tags 0,1,2,3.
REQ-033 SHALL cover full plus simultaneous push/pop: level=4, out_ready=1, in_valid=1 with 20'hABCDE -> level stays 4, drop_cnt unchanged, 20'hABCDE emerges fourth.
REQ-034 SHALL cover tag wrap: 17 accepted captures with continuous drain -> tags 0..15 then 0.
REQ-035 SHALL cover flush and reset mid-operation: level=3, flush=1 one cycle alongside in_valid=1 -> level=0, drop_cnt unchanged, next tag continues; then resetn=0 with level=2 -> all outputs 0 next cycle.
REQ-036 SHALL cover parity with CC_CAPTURE_PARITY_EN: capture 20'h00007 -> out_par=1; capture 20'h00003 -> out_par=0; without macro out_par=0 for both.
